// File: rtl/idct_row_seq.sv
// -----------------------------------------------------------------------------
// idct_row_seq
//
// Block-level sequencer for the serial row-IDCT datapath. Accepts one transform
// request at a time (block size + coefficient base address), reads the block's
// coefficients from the coefficient RAM in row-major order, and streams them
// one per cycle into the datapath together with a steady size code (idct4).
// After the last coefficient, idct4 is held for a drain window so the final
// row's results leave the datapath. A one-cycle done pulse follows, and idct4
// returns to idle before the next block can start.
//
// Ports:
//   clk          clock
//   rst_n        synchronous reset, active low
//   req_valid    transform request present
//   req_ready    sequencer can accept a request (IDLE and not in reset)
//   req_size     0 = 4x4 block, 1 = 8x8 block (latched at accept)
//   req_base     RAM address of coefficient 0 (latched at accept)
//   mem_rd_en    RAM read strobe
//   mem_addr     RAM read address (wraps modulo 2^AW, holds when idle)
//   mem_rd_data  RAM read data, valid one cycle after mem_rd_en
//   idct4        size code to datapath: 00 idle, 01 4-point, 10 8-point
//   x_out        serial coefficient to datapath (0 while draining)
//   busy         high from accept until done inclusive
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module idct_row_seq #(
   parameter int AW      = 10,
   parameter int WIDTH_X = 16,
   parameter int FLUSH   = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_size,
   input  logic [AW-1:0]      req_base,
   output logic               mem_rd_en,
   output logic [AW-1:0]      mem_addr,
   input  logic [WIDTH_X-1:0] mem_rd_data,
   output logic [1:0]         idct4,
   output logic [WIDTH_X-1:0] x_out,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [7:0] FLUSH_LAST = 8'(FLUSH - 1);

   logic [1:0] state;
   logic       size_q;       // latched block size
   logic [5:0] coef_cnt;     // 0..T-1
   logic [7:0] flush_cnt;    // 0..FLUSH-1
   logic       rd_vld;       // mem_rd_data carries a coefficient this cycle
   logic       x_vld;        // x_out carries a coefficient this cycle

   logic       accept;
   logic       last_coef;
   logic       drain_empty;
   logic       flush_last;
   logic [1:0] code;

   assign req_ready = rst_n && (state == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   assign code      = size_q ? 2'b10 : 2'b01;
   assign last_coef = (coef_cnt == (size_q ? 6'd63 : 6'd15));

   // The FLUSH state is entered right after the last read, while the last two
   // coefficients are still in the RAM/x_out pipeline. The drain window only
   // starts counting once that pipeline is empty, so idct4 stays non-zero for
   // exactly FLUSH cycles of x_out = 0.
   assign drain_empty = !rd_vld && !x_vld;
   assign flush_last  = (state == S_FLUSH) && drain_empty && (flush_cnt == FLUSH_LAST);

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values; the reset branch clears every flop (there is no RAM
   // here), which also cancels any in-flight read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         size_q    <= 1'b0;
         coef_cnt  <= '0;
         flush_cnt <= '0;
         rd_vld    <= 1'b0;
         x_vld     <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         idct4     <= 2'b00;
         x_out     <= '0;
      end else begin
         // Read pipeline: strobe -> data valid -> x_out register.
         rd_vld <= mem_rd_en;
         x_vld  <= rd_vld;
         x_out  <= rd_vld ? mem_rd_data : '0;

         // idct4 rises together with the first coefficient on x_out and
         // stays at the block's code until the cycle before DONE.
         idct4 <= (rd_vld || ((state == S_FLUSH) && !flush_last)) ? code : 2'b00;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  state     <= S_RUN;
                  size_q    <= req_size;
                  mem_addr  <= req_base;
                  mem_rd_en <= 1'b1;
                  coef_cnt  <= '0;
                  flush_cnt <= '0;
               end
            end
            S_RUN: begin
               if (last_coef) begin
                  // Address holds on the last coefficient's location.
                  mem_rd_en <= 1'b0;
                  state     <= S_FLUSH;
               end else begin
                  coef_cnt <= coef_cnt + 6'd1;
                  mem_addr <= mem_addr + AW'(1);
               end
            end
            S_FLUSH: begin
               if (drain_empty) begin
                  if (flush_last) begin
                     flush_cnt <= '0;
                     state     <= S_DONE;
                  end else begin
                     flush_cnt <= flush_cnt + 8'd1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_idct_row_seq.sv
// -----------------------------------------------------------------------------
// tb_idct_row_seq
//
// Scoreboard bench for idct_row_seq. Stimulus pushes the expected read
// addresses, the expected (idct4, x_out) stream and the expected done cycle
// into queues, stamped with absolute cycle numbers. A monitor samples the DUT
// on the falling edge and pops/compares whenever an output is due or active.
// The RAM model returns RAM[a] = a.
// -----------------------------------------------------------------------------
module tb_idct_row_seq;

   localparam int AW      = 10;
   localparam int WIDTH_X = 16;
   localparam int FLUSH   = 12;

   logic               clk;
   logic               rst_n;
   logic               req_valid;
   logic               req_ready;
   logic               req_size;
   logic [AW-1:0]      req_base;
   logic               mem_rd_en;
   logic [AW-1:0]      mem_addr;
   logic [WIDTH_X-1:0] mem_rd_data;
   logic [1:0]         idct4;
   logic [WIDTH_X-1:0] x_out;
   logic               busy;
   logic               done;

   idct_row_seq #(.AW(AW), .WIDTH_X(WIDTH_X), .FLUSH(FLUSH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_size   (req_size),
      .req_base   (req_base),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .idct4      (idct4),
      .x_out      (x_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute cycle number: the cycle following edge n has cyc == n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= {{(WIDTH_X-AW){1'b0}}, mem_addr};
   end

   typedef struct {
      int          cyc;
      logic [15:0] val;
      logic [1:0]  code;
   } exp_t;

   exp_t aq[$];   // expected reads
   exp_t xq[$];   // expected idct4/x_out stream
   exp_t dq[$];   // expected done pulses

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;
   int blk_start = 1;
   int blk_end   = 0;
   int last_done_cyc = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         logic in_blk;
         if (aq.size() > 0 && aq[0].cyc == cyc) begin
            e = aq.pop_front();
            check("rd_en", 32'(mem_rd_en), 32'd1);
            check("mem_addr", 32'(mem_addr), 32'(e.val));
         end else begin
            check("rd_en_idle", 32'(mem_rd_en), 32'd0);
         end

         if (xq.size() > 0 && xq[0].cyc == cyc) begin
            e = xq.pop_front();
            check("idct4", 32'(idct4), 32'(e.code));
            check("x_out", 32'(x_out), 32'(e.val));
         end else begin
            check("idct4_idle", 32'(idct4), 32'd0);
            check("x_out_idle", 32'(x_out), 32'd0);
         end

         if (dq.size() > 0 && dq[0].cyc == cyc) begin
            e = dq.pop_front();
            check("done", 32'(done), 32'd1);
         end else begin
            check("done_idle", 32'(done), 32'd0);
         end
         if (done === 1'b1) last_done_cyc = cyc;

         in_blk = (cyc >= blk_start) && (cyc <= blk_end);
         check("busy", 32'(busy), 32'(in_blk));
         check("req_ready", 32'(req_ready), 32'(rst_n && !in_blk));
      end
   end

   // Issue one request; called at posedge+1. Returns the accepting edge
   // number (block cycle 0 has cyc == a).
   task automatic issue(input logic sz, input logic [AW-1:0] base, input bit hold_valid,
                        output int a);
      int n;
      int t;
      logic [1:0] c;
      bit ok;
      req_valid = 1'b1;
      req_size  = sz;
      req_base  = base;
      ok = 1'b0;
      a  = -1;
      for (int g = 0; g < 300; g++) begin
         if (req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      a = cyc + 1;
      n = sz ? 8 : 4;
      t = n * n;
      c = sz ? 2'b10 : 2'b01;
      for (int i = 0; i < t; i++)
         aq.push_back('{cyc: a + i, val: 16'((32'(base) + i) % 1024), code: 2'b00});
      for (int k = 2; k <= t + 1 + FLUSH; k++)
         xq.push_back('{cyc: a + k,
                        val: (k - 2 < t) ? 16'((32'(base) + k - 2) % 1024) : 16'd0,
                        code: c});
      dq.push_back('{cyc: a + t + 2 + FLUSH, val: 16'd0, code: 2'b00});
      blk_start = a;
      blk_end   = a + t + 2 + FLUSH;
      @(posedge clk); #1;
      if (!hold_valid) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int g = 0; g < 300; g++) begin
         if (cyc > blk_end + 1) return;
         @(posedge clk); #1;
      end
      check("idle_timeout", 32'd0, 32'd1);
   endtask

   int a1, a2;

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_size  = 1'b0;
      req_base  = '0;
      @(posedge clk); #1;
      mon_en = 1'b1;          // reset state checked by the monitor from here
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // 4x4 at 0x010: done in block cycle 30, ready again in 31.
      issue(1'b0, 10'h010, 1'b0, a1);
      wait_idle();
      check("t1_done_cycle", 32'(last_done_cyc - a1), 32'd30);

      // 8x8 at 0x100: done in block cycle 78.
      issue(1'b1, 10'h100, 1'b0, a1);
      wait_idle();
      check("t2_done_cycle", 32'(last_done_cyc - a1), 32'd78);

      // Back-to-back with req_valid held: second accept at end of cycle 31.
      issue(1'b0, 10'h020, 1'b1, a1);
      issue(1'b1, 10'h080, 1'b0, a2);
      check("b2b_accept_gap", 32'(a2 - a1), 32'd32);
      wait_idle();

      // Address wrap at the top of the RAM.
      issue(1'b1, 10'h3F0, 1'b0, a1);
      wait_idle();
      check("wrap_done_cycle", 32'(last_done_cyc - a1), 32'd78);

      // Reset in block cycle 20 of an 8x8 block: no done, outputs cleared.
      issue(1'b1, 10'h100, 1'b0, a1);
      while (cyc < a1 + 20) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      while (aq.size() > 0 && aq[$].cyc > cyc) void'(aq.pop_back());
      while (xq.size() > 0 && xq[$].cyc > cyc) void'(xq.pop_back());
      while (dq.size() > 0 && dq[$].cyc > cyc) void'(dq.pop_back());
      blk_end = cyc;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_ready", 32'(req_ready), 32'd1);
      issue(1'b0, 10'h005, 1'b0, a1);
      wait_idle();
      check("post_reset_done", 32'(last_done_cyc - a1), 32'd30);

      // Request inputs change while busy; the stream must not follow them.
      issue(1'b1, 10'h200, 1'b0, a1);
      repeat (3) begin @(posedge clk); #1; end
      req_size = 1'b0;
      req_base = 10'h3FF;
      wait_idle();
      check("stable_done_cycle", 32'(last_done_cyc - a1), 32'd78);

      repeat (4) begin @(posedge clk); #1; end
      check("addr_queue_empty", 32'(aq.size()), 32'd0);
      check("x_queue_empty", 32'(xq.size()), 32'd0);
      check("done_queue_empty", 32'(dq.size()), 32'd0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
